fetch_inst_buffer: RTL and testbench

//  Circular instruction queue between fetch and decode/dispatch. Each fetch-group lane carries

---
 rtl/fetch_inst_buffer.sv | 159 +++++++++++++++
 tb/tb_fetch_inst_buffer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_inst_buffer.sv
// Circular instruction queue between fetch and decode: enqueues up to IN_WIDTH lanes per cycle
// (compacted, truncated after the first unconditional branch) and presents OUT_WIDTH head lanes.
module fetch_inst_buffer #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned IN_WIDTH  = 2,
  parameter int unsigned OUT_WIDTH = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [IN_WIDTH-1:0]            if_valid,
  input  logic [IN_WIDTH*32-1:0]         if_inst,
  input  logic [IN_WIDTH*32-1:0]         if_pc,
  input  logic [IN_WIDTH-1:0]            if_cond_br,
  input  logic [IN_WIDTH-1:0]            if_uncond_br,
  input  logic [IN_WIDTH-1:0]            if_jump,
  input  logic [IN_WIDTH-1:0]            if_jump_back,
  output logic                           if_ready,
  input  logic [$clog2(OUT_WIDTH+1)-1:0] id_take,
  output logic [OUT_WIDTH-1:0]           id_valid,
  output logic [OUT_WIDTH*32-1:0]        id_inst,
  output logic [OUT_WIDTH*32-1:0]        id_pc,
  output logic [OUT_WIDTH*32-1:0]        id_npc,
  output logic [OUT_WIDTH-1:0]           id_cond_br,
  output logic [OUT_WIDTH-1:0]           id_uncond_br,
  output logic [OUT_WIDTH-1:0]           id_jump,
  output logic [OUT_WIDTH-1:0]           id_jump_back,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned TAKE_W = $clog2(OUT_WIDTH + 1);
  localparam int unsigned WR_W   = $clog2(IN_WIDTH + 1);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        cond_br;
    logic        uncond_br;
    logic        jump;
    logic        jump_back;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  entry_t             in_ent [IN_WIDTH];
  entry_t             rd_ent [OUT_WIDTH];
  logic [IN_WIDTH-1:0] wr_en;
  logic [PTR_W-1:0]   wr_off [IN_WIDTH];
  logic [WR_W-1:0]    wr_cnt;
  logic               trunc;
  logic               enq_ok;
  logic [TAKE_W-1:0]  take_eff;

  // Registered occupancy only; a same-cycle dequeue does not free space for fetch.
  assign if_ready = (count_q <= CNT_W'(DEPTH - IN_WIDTH));
  assign count    = count_q;
  assign enq_ok   = if_ready && !flush;
  assign take_eff = flush ? '0 : id_take;

  always_comb begin
    for (int i = 0; i < IN_WIDTH; i++) begin
      in_ent[i].inst      = if_inst[i*32 +: 32];
      in_ent[i].pc        = if_pc[i*32 +: 32];
      in_ent[i].cond_br   = if_cond_br[i];
      in_ent[i].uncond_br = if_uncond_br[i];
      in_ent[i].jump      = if_jump[i];
      in_ent[i].jump_back = if_jump_back[i];
    end
  end

  // Compact valid lanes onto consecutive tail slots; stop after the first uncond branch.
  always_comb begin
    wr_en  = '0;
    wr_cnt = '0;
    trunc  = 1'b0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      wr_off[i] = PTR_W'(wr_cnt);
      if (enq_ok && if_valid[i] && !trunc) begin
        wr_en[i] = 1'b1;
        wr_cnt   = wr_cnt + WR_W'(1);
        trunc    = if_uncond_br[i];
      end
    end
  end

  always_comb begin
    head_d  = head_q + PTR_W'(take_eff);
    tail_d  = tail_q + PTR_W'(wr_cnt);
    count_d = count_q + CNT_W'(wr_cnt) - CNT_W'(take_eff);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset: occupancy gates everything visible.
  always_ff @(posedge clock) begin
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (wr_en[i] && !reset) begin
        mem_q[tail_q + wr_off[i]] <= in_ent[i];
      end
    end
  end

  always_comb begin
    for (int j = 0; j < OUT_WIDTH; j++) begin
      rd_ent[j] = mem_q[head_q + PTR_W'(j)];
    end
  end

  always_comb begin
    id_valid     = '0;
    id_inst      = '0;
    id_pc        = '0;
    id_npc       = '0;
    id_cond_br   = '0;
    id_uncond_br = '0;
    id_jump      = '0;
    id_jump_back = '0;
    for (int j = 0; j < OUT_WIDTH; j++) begin
      if (count_q > CNT_W'(j)) begin
        id_valid[j]        = 1'b1;
        id_inst[j*32 +: 32] = rd_ent[j].inst;
        id_pc[j*32 +: 32]   = rd_ent[j].pc;
        id_npc[j*32 +: 32]  = rd_ent[j].pc + 32'd4;
        id_cond_br[j]      = rd_ent[j].cond_br;
        id_uncond_br[j]    = rd_ent[j].uncond_br;
        id_jump[j]         = rd_ent[j].jump;
        id_jump_back[j]    = rd_ent[j].jump_back;
      end
    end
  end

  // Decode may never take more lanes than are presented valid.
  always_ff @(posedge clock) begin
    if (!reset && !flush) begin
      assert (id_take <= TAKE_W'(OUT_WIDTH) && CNT_W'(id_take) <= count_q);
    end
  end

endmodule

// File: tb/tb_fetch_inst_buffer.sv
// Bench for fetch_inst_buffer: directed scenarios plus random traffic against a queue model.
module tb_fetch_inst_buffer;

  logic        clock;
  logic        reset;
  logic        flush;
  logic [1:0]  if_valid;
  logic [63:0] if_inst;
  logic [63:0] if_pc;
  logic [1:0]  if_cond_br;
  logic [1:0]  if_uncond_br;
  logic [1:0]  if_jump;
  logic [1:0]  if_jump_back;
  logic        if_ready;
  logic [1:0]  id_take;
  logic [1:0]  id_valid;
  logic [63:0] id_inst;
  logic [63:0] id_pc;
  logic [63:0] id_npc;
  logic [1:0]  id_cond_br;
  logic [1:0]  id_uncond_br;
  logic [1:0]  id_jump;
  logic [1:0]  id_jump_back;
  logic [4:0]  count;

  fetch_inst_buffer #(.DEPTH(16), .IN_WIDTH(2), .OUT_WIDTH(2)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .if_cond_br(if_cond_br), .if_uncond_br(if_uncond_br),
    .if_jump(if_jump), .if_jump_back(if_jump_back),
    .if_ready(if_ready), .id_take(id_take),
    .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc), .id_npc(id_npc),
    .id_cond_br(id_cond_br), .id_uncond_br(id_uncond_br),
    .id_jump(id_jump), .id_jump_back(id_jump_back), .count(count)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [3:0]  fl;   // {cond, uncond, jump, jump_back}
  } ent_t;

  ent_t mq[$];
  ent_t ne;
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   chk_en = 0;
  bit   m_rdy;
  logic [31:0] e_inst, e_pc, e_npc;
  logic [3:0]  e_fl;
  logic        e_val;

  localparam logic [31:0] ADD = 32'h0000_0033;
  localparam logic [31:0] JAL = 32'h0000_006F;
  localparam logic [31:0] BEQ = 32'h0000_0063;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a plain FIFO of lanes; occupancy and head lanes follow directly from it.
  always @(posedge clock) begin
    if (reset || flush) begin
      mq.delete();
    end else begin
      m_rdy = (16 - mq.size()) >= 2;
      for (int k = 0; k < int'(id_take); k++) begin
        if (mq.size() > 0) void'(mq.pop_front());
      end
      if (m_rdy) begin
        for (int i = 0; i < 2; i++) begin
          if (if_valid[i]) begin
            ne.inst = if_inst[i*32 +: 32];
            ne.pc   = if_pc[i*32 +: 32];
            ne.fl   = {if_cond_br[i], if_uncond_br[i], if_jump[i], if_jump_back[i]};
            mq.push_back(ne);
            if (if_uncond_br[i]) break;
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("count", 32'(count), 32'(mq.size()));
      chk("if_ready", 32'(if_ready), 32'((16 - mq.size()) >= 2));
      for (int j = 0; j < 2; j++) begin
        e_val = (j < mq.size());
        e_inst = e_val ? mq[j].inst : 32'h0;
        e_pc   = e_val ? mq[j].pc : 32'h0;
        e_npc  = e_val ? mq[j].pc + 32'd4 : 32'h0;
        e_fl   = e_val ? mq[j].fl : 4'h0;
        chk($sformatf("id_valid[%0d]", j), 32'(id_valid[j]), 32'(e_val));
        chk($sformatf("id_inst[%0d]", j), id_inst[j*32 +: 32], e_inst);
        chk($sformatf("id_pc[%0d]", j), id_pc[j*32 +: 32], e_pc);
        chk($sformatf("id_npc[%0d]", j), id_npc[j*32 +: 32], e_npc);
        chk($sformatf("id_flags[%0d]", j),
            32'({id_cond_br[j], id_uncond_br[j], id_jump[j], id_jump_back[j]}), 32'(e_fl));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    flush = 0; if_valid = '0; if_inst = '0; if_pc = '0; id_take = '0;
    if_cond_br = '0; if_uncond_br = '0; if_jump = '0; if_jump_back = '0;
  endtask

  task automatic lane(input int i, input logic [31:0] inst, input logic [31:0] pc,
                      input logic [3:0] fl);
    if_valid[i] = 1'b1;
    if_inst[i*32 +: 32] = inst;
    if_pc[i*32 +: 32] = pc;
    {if_cond_br[i], if_uncond_br[i], if_jump[i], if_jump_back[i]} = fl;
  endtask

  task automatic group(input logic [31:0] pc0);
    if_valid = '0;
    lane(0, ADD, pc0, 4'h0);
    lane(1, ADD, pc0 + 32'd4, 4'h0);
  endtask

  int maxt;
  logic [31:0] pcs;

  initial begin
    idle();
    reset = 1;
    group(32'h900);
    tick();
    chk_en = 1;
    tick();
    reset = 0;
    idle();
    @(negedge clock);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(if_ready), 32'd1);
    chk("rst_valid", 32'(id_valid), 32'd0);

    // Fill to full; ninth group dropped, then drain in order.
    for (int g = 0; g < 9; g++) begin
      group(32'(g * 8));
      tick();
    end
    idle();
    @(negedge clock);
    chk("full_count", 32'(count), 32'd16);
    chk("full_ready", 32'(if_ready), 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      chk("drain_pc0", id_pc[31:0], 32'(k * 8));
      chk("drain_npc1", id_npc[63:32], 32'(k * 8 + 8));
      id_take = 2;
      tick();
    end
    idle();

    // Truncation after a JAL lane.
    if_valid = '0;
    lane(0, JAL, 32'h100, 4'b0110);
    lane(1, ADD, 32'h104, 4'h0);
    tick();
    idle();
    @(negedge clock);
    chk("trunc_count", 32'(count), 32'd1);
    group(32'h300);
    tick();
    idle();
    @(negedge clock);
    chk("trunc_jump0", 32'(id_jump[0]), 32'd1);
    chk("trunc_pc1", id_pc[63:32], 32'h300);
    flush = 1;
    tick();
    idle();

    // Compaction of a lone lane 1.
    lane(1, BEQ, 32'h208, 4'b1000);
    if_inst[31:0] = 32'hDEAD_BEEF;
    tick();
    idle();
    @(negedge clock);
    chk("cmp_pc0", id_pc[31:0], 32'h208);
    chk("cmp_cond0", 32'(id_cond_br[0]), 32'd1);
    chk("cmp_valid", 32'(id_valid), 32'd1);

    // Build up to 14, then enqueue and dequeue together across the wrap.
    for (int g = 0; g < 6; g++) begin
      group(32'h400 + 32'(g * 8));
      tick();
    end
    idle();
    lane(0, ADD, 32'h430, 4'h0);
    tick();
    pcs = 32'h500;
    for (int k = 0; k < 10; k++) begin
      group(pcs);
      pcs = pcs + 32'd8;
      id_take = 2;
      tick();
      idle();
      @(negedge clock);
      chk("wrap_count", 32'(count), 32'd14);
    end

    // Flush from 9 entries.
    id_take = 2; tick();
    id_take = 2; tick();
    id_take = 1; tick();
    idle();
    @(negedge clock);
    chk("pre_flush_count", 32'(count), 32'd9);
    group(32'h700);
    flush = 1;
    id_take = 2;
    tick();
    idle();
    @(negedge clock);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(id_valid), 32'd0);
    chk("flush_ready", 32'(if_ready), 32'd1);
    group(32'h600);
    tick();
    idle();
    @(negedge clock);
    chk("post_flush_pc0", id_pc[31:0], 32'h600);
    chk("post_flush_count", 32'(count), 32'd2);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 39) == 0);
      if_valid = 2'($urandom_range(0, 3));
      if_inst = {$urandom(), $urandom()};
      if_pc = {$urandom(), $urandom()};
      if_cond_br = 2'($urandom_range(0, 3));
      if_jump = 2'($urandom_range(0, 3));
      if_jump_back = 2'($urandom_range(0, 3));
      for (int i = 0; i < 2; i++) if_uncond_br[i] = ($urandom_range(0, 3) == 0);
      maxt = (mq.size() < 2) ? mq.size() : 2;
      id_take = ($urandom_range(0, 2) == 0) ? 2'd0 : 2'($urandom_range(0, maxt));
      tick();
    end
    reset = 0;
    idle();
    tick();
    @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
